fpu_share_ctrl: RTL

Sequencing controller that shares one FPU instance (`fpu_top` / `fpu_core`) among `NUM_REQ` processing-element requesters. It sits between the PE-side request ports and the single FPU. It picks one request per round by round-robin, issues the request to the FPU for exactly one cycle, and waits for the FPU valid strobe. It then returns the result to the originating requester. Exactly one operation is in flight at a time, and a watchdog recovers from a missing FPU valid.

---
 rtl/fpu_share_pkg.sv | 24 ++
 rtl/fpu_share_ctrl_rr_pick.sv | 54 +++++
 rtl/fpu_share_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fpu_share_pkg.sv
// ---------------------------------------------------------------------------
// fpu_share_pkg
// Shared types and constants for the FPU sharing controller.
//   fpu_share_state_e : controller FSM states
//   FPU_OP_W          : FPU opcode width
//   FPU_DATA_W        : FPU operand / result width
//   FPU_QNAN          : result returned when the FPU never answers
//   FPU_NOM_LAT       : nominal FPU latency (enable to valid), in cycles
// ---------------------------------------------------------------------------
package fpu_share_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } fpu_share_state_e;

    localparam int FPU_OP_W    = 6;
    localparam int FPU_DATA_W  = 32;
    localparam logic [FPU_DATA_W-1:0] FPU_QNAN = 32'h7FC0_0000;
    localparam int FPU_NOM_LAT = 2;

endpackage

// File: rtl/fpu_share_ctrl_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Picks the lowest requesting index at
// or after ptr, wrapping modulo N.
//   req     : request vector
//   ptr     : index with highest priority this round (must be < N)
//   gnt     : one-hot grant (all zero when no request)
//   gnt_idx : binary index of the grant (0 when no request)
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int IDX_W = $clog2(N);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic           found;
    logic [IDX_W:0] sum;

    // Doubling the vector lets a plain part-select produce the request
    // vector rotated so that bit 0 corresponds to ptr.
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[{1'b0, ptr} +: N];

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        for (int j = 0; j < N; j++) begin
            if (!found && req_rot[j]) begin
                found = 1'b1;
                // Map the rotated position back to the absolute index.
                sum = {1'b0, ptr} + (IDX_W+1)'(j);
                if (sum >= (IDX_W+1)'(N)) begin
                    sum = sum - (IDX_W+1)'(N);
                end
                gnt_idx = sum[IDX_W-1:0];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_gnt
            assign gnt[gi] = found && (gnt_idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/fpu_share_ctrl.sv
// ---------------------------------------------------------------------------
// fpu_share_ctrl
// Shares a single FPU among NUM_REQ requesters. One operation is in flight
// at a time: accept (IDLE) -> one-cycle enable (ISSUE) -> wait for the FPU
// valid strobe or a watchdog timeout (WAIT) -> one-cycle response (RESP).
//
// Ports
//   Clk, Reset     : clock (rising edge), asynchronous active-high reset
//   req_valid_i    : per-requester request valid
//   req_ready_o    : per-requester accept (combinational, one-hot or zero)
//   req_op_i       : packed opcodes, requester k at [6k+5:6k]
//   req_a_i/_b_i   : packed operands, requester k at [32k+31:32k]
//   resp_valid_o   : one-hot, one-cycle response strobe
//   resp_data_o    : result, qualified by resp_valid_o
//   resp_err_o     : timeout flag, qualified by resp_valid_o
//   fpu_en_o       : one-cycle issue strobe to the FPU
//   fpu_op_o/a/b_o : operation presented to the FPU
//   fpu_result_i   : FPU result
//   fpu_valid_i    : FPU result valid (only honoured in WAIT)
//   busy_o         : high whenever the controller is not idle
// ---------------------------------------------------------------------------
module fpu_share_ctrl
    import fpu_share_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ*FPU_OP_W-1:0]    req_op_i,
    input  logic [NUM_REQ*FPU_DATA_W-1:0]  req_a_i,
    input  logic [NUM_REQ*FPU_DATA_W-1:0]  req_b_i,
    output logic [NUM_REQ-1:0]             resp_valid_o,
    output logic [FPU_DATA_W-1:0]          resp_data_o,
    output logic                           resp_err_o,
    output logic                           fpu_en_o,
    output logic [FPU_OP_W-1:0]            fpu_op_o,
    output logic [FPU_DATA_W-1:0]          fpu_a_o,
    output logic [FPU_DATA_W-1:0]          fpu_b_o,
    input  logic [FPU_DATA_W-1:0]          fpu_result_i,
    input  logic                           fpu_valid_i,
    output logic                           busy_o
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int WCNT_W = $clog2(MAX_WAIT) + 1;

    fpu_share_state_e state_reg;
    fpu_share_state_e state_next;

    logic [IDX_W-1:0]      rr_ptr_reg;
    logic [IDX_W-1:0]      rr_ptr_next;
    logic [IDX_W-1:0]      idx_reg;
    logic [WCNT_W-1:0]     wait_cnt_reg;
    logic [FPU_OP_W-1:0]   op_reg;
    logic [FPU_DATA_W-1:0] a_reg;
    logic [FPU_DATA_W-1:0] b_reg;
    logic                  en_reg;
    logic [FPU_DATA_W-1:0] result_reg;
    logic                  err_reg;
    logic [NUM_REQ-1:0]    resp_valid_reg;
    logic                  busy_reg;

    logic [NUM_REQ-1:0]    gnt;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  req_any;
    logic                  accept;
    logic                  timeout;
    logic [NUM_REQ-1:0]    resp_onehot;

    logic [FPU_OP_W-1:0]   op_arr [NUM_REQ];
    logic [FPU_DATA_W-1:0] a_arr  [NUM_REQ];
    logic [FPU_DATA_W-1:0] b_arr  [NUM_REQ];

    // ------------------------------------------------------------------
    // Arbiter and per-requester views of the packed payload buses
    // ------------------------------------------------------------------
    rr_pick #(
        .N       (NUM_REQ)
    ) u_rr_pick (
        .req     (req_valid_i),
        .ptr     (rr_ptr_reg),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign op_arr[gi]      = req_op_i[gi*FPU_OP_W +: FPU_OP_W];
            assign a_arr[gi]       = req_a_i[gi*FPU_DATA_W +: FPU_DATA_W];
            assign b_arr[gi]       = req_b_i[gi*FPU_DATA_W +: FPU_DATA_W];
            assign resp_onehot[gi] = (idx_reg == IDX_W'(gi));
        end
    endgenerate

    assign req_any     = |req_valid_i;
    assign accept      = (state_reg == IDLE) && req_any;
    assign timeout     = (wait_cnt_reg == WCNT_W'(MAX_WAIT - 1));
    assign rr_ptr_next = (idx_reg == IDX_W'(NUM_REQ - 1)) ? '0 : idx_reg + IDX_W'(1);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_any) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            // A valid strobe on the timeout cycle still counts as a result.
            WAIT:    if (fpu_valid_i || timeout) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Ready is the only combinational output; it is held
    // low while Reset is asserted so no handshake can complete then.
    // ------------------------------------------------------------------
    always_comb begin
        req_ready_o = '0;
        if ((state_reg == IDLE) && !Reset) begin
            req_ready_o = gnt;
        end
    end

    assign resp_valid_o = resp_valid_reg;
    assign resp_data_o  = result_reg;
    assign resp_err_o   = err_reg;
    assign fpu_en_o     = en_reg;
    assign fpu_op_o     = op_reg;
    assign fpu_a_o      = a_reg;
    assign fpu_b_o      = b_reg;
    assign busy_o       = busy_reg;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rr_ptr_reg     <= '0;
            idx_reg        <= '0;
            wait_cnt_reg   <= '0;
            op_reg         <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            en_reg         <= 1'b0;
            result_reg     <= '0;
            err_reg        <= 1'b0;
            resp_valid_reg <= '0;
            busy_reg       <= 1'b0;
        end else begin
            en_reg         <= accept;
            busy_reg       <= (state_next != IDLE);
            resp_valid_reg <= '0;

            // Payload is sampled only at the handshake and then held for
            // the FPU until the next accept.
            if (accept) begin
                idx_reg <= gnt_idx;
                op_reg  <= op_arr[gnt_idx];
                a_reg   <= a_arr[gnt_idx];
                b_reg   <= b_arr[gnt_idx];
            end

            case (state_reg)
                ISSUE: begin
                    wait_cnt_reg <= '0;
                end
                WAIT: begin
                    wait_cnt_reg <= wait_cnt_reg + WCNT_W'(1);
                    if (fpu_valid_i) begin
                        result_reg     <= fpu_result_i;
                        err_reg        <= 1'b0;
                        resp_valid_reg <= resp_onehot;
                    end else if (timeout) begin
                        result_reg     <= FPU_QNAN;
                        err_reg        <= 1'b1;
                        resp_valid_reg <= resp_onehot;
                    end
                end
                RESP: begin
                    rr_ptr_reg <= rr_ptr_next;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
